// File: rtl/tl_ram_slave_if.sv
// TileLink-UL A/D channel bundle between one crossbar port and one responder.
// The master modport drives requests; the slave modport drives responses.
interface tl_ram_slave_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_size;
  logic [3:0]  a_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic [63:0] d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
  );
endinterface

// File: rtl/tl_ram_slave.sv
// TileLink-UL responder over a synchronous 64-bit RAM: single-beat Put, burst Get.
// Define TL_RAM_WAIT_EN to insert WAIT_CYCLES stall cycles before every response.
module tl_ram_slave #(
  parameter logic [63:0] BASE        = 64'h0000_0000_8000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          MAX_SIZE    = 6,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  tl_ram_slave_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
  localparam logic [2:0]  OP_PUTF  = 3'd0;
  localparam logic [2:0]  OP_PUTP  = 3'd1;
  localparam logic [2:0]  OP_GET   = 3'd4;
  localparam logic [2:0]  D_ACK    = 3'd0;
  localparam logic [2:0]  D_ACKD   = 3'd1;

  typedef enum logic [1:0] {IDLE, READ, RESP, WAIT} state_t;

`ifdef TL_RAM_WAIT_EN
  localparam bit          USE_WAIT = (WAIT_CYCLES != 0);
  localparam int          CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  logic [CW-1:0] wait_cnt_r;
`else
  localparam bit          USE_WAIT = (WAIT_CYCLES < 0);
`endif
  localparam state_t      RESP_ENTRY  = USE_WAIT ? WAIT : RESP;
  localparam bit          DIRECT_RESP = !USE_WAIT;

  state_t        state_r;
  logic          a_ready_r;
  logic          d_valid_r;
  logic [2:0]    d_opcode_r;
  logic [2:0]    d_size_r;
  logic [3:0]    d_source_r;
  logic          d_denied_r;
  logic [63:0]   d_data_r;
  logic [AW-1:0] idx_r;
  logic [3:0]    beats_left_r;
  logic [63:0]   ram_q_r;
  logic [63:0]   mem [DEPTH];

  logic [63:0]   offset_s;
  logic [63:0]   align_mask_s;
  logic          is_get_s;
  logic          is_put_s;
  logic          legal_s;
  logic [3:0]    beats_m1_s;
  logic [AW-1:0] a_idx_s;
  logic          accept_s;
  logic          d_fire_s;
  logic          more_s;
  logic          ram_we_s;
  logic          ram_re_s;
  logic [AW-1:0] ram_idx_s;

  assign offset_s     = bus.a_address - BASE;
  assign align_mask_s = (64'd1 << bus.a_size) - 64'd1;
  assign is_get_s     = (bus.a_opcode == OP_GET);
  assign is_put_s     = (bus.a_opcode == OP_PUTF) || (bus.a_opcode == OP_PUTP);
  assign legal_s      = (is_get_s || is_put_s)
                     && (offset_s < SPAN)
                     && (bus.a_size <= 3'(MAX_SIZE))
                     && ((offset_s & align_mask_s) == 64'd0)
                     && !(is_put_s && (bus.a_size > 3'd3));
  assign a_idx_s      = offset_s[AW+2:3];
  assign accept_s     = (state_r == IDLE) && bus.a_valid && a_ready_r;
  assign d_fire_s     = (state_r == RESP) && d_valid_r && bus.d_ready;
  assign more_s       = (beats_left_r != 4'd0);
  assign ram_we_s     = accept_s && legal_s && is_put_s;
  assign ram_re_s     = (accept_s && legal_s && is_get_s) || (d_fire_s && more_s && !d_denied_r);
  assign ram_idx_s    = accept_s ? a_idx_s : idx_r + AW'(1);

  // Remaining beats after the first; a denied Get still returns its full burst.
  always_comb begin
    beats_m1_s = 4'd0;
    if (is_get_s) begin
      case (bus.a_size)
        3'd4:    beats_m1_s = 4'd1;
        3'd5:    beats_m1_s = 4'd3;
        3'd6:    beats_m1_s = 4'd7;
        3'd7:    beats_m1_s = 4'd15;
        default: beats_m1_s = 4'd0;
      endcase
    end else begin
      beats_m1_s = 4'd0;
    end
  end

  // RAM array: byte-masked write and registered read, contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.a_mask[i]) begin
          mem[ram_idx_s][8*i +: 8] <= bus.a_data[8*i +: 8];
        end
      end
    end
    if (ram_re_s) begin
      ram_q_r <= mem[ram_idx_s];
    end
  end

  // Request/response FSM with registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      a_ready_r    <= 1'b0;
      d_valid_r    <= 1'b0;
      d_opcode_r   <= 3'd0;
      d_size_r     <= 3'd0;
      d_source_r   <= 4'd0;
      d_denied_r   <= 1'b0;
      d_data_r     <= 64'd0;
      idx_r        <= '0;
      beats_left_r <= 4'd0;
`ifdef TL_RAM_WAIT_EN
      wait_cnt_r   <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          a_ready_r <= 1'b1;
          if (accept_s) begin
            a_ready_r    <= 1'b0;
            d_size_r     <= bus.a_size;
            d_source_r   <= bus.a_source;
            d_denied_r   <= !legal_s;
            d_opcode_r   <= is_get_s ? D_ACKD : D_ACK;
            d_data_r     <= 64'd0;
            idx_r        <= a_idx_s;
            beats_left_r <= beats_m1_s;
            if (legal_s && is_get_s) begin
              state_r <= READ;
            end else begin
              state_r   <= RESP_ENTRY;
              d_valid_r <= DIRECT_RESP;
`ifdef TL_RAM_WAIT_EN
              wait_cnt_r <= WAIT_LOAD;
`endif
            end
          end
        end
        READ: begin
          d_data_r  <= d_denied_r ? 64'd0 : ram_q_r;
          state_r   <= RESP_ENTRY;
          d_valid_r <= DIRECT_RESP;
`ifdef TL_RAM_WAIT_EN
          wait_cnt_r <= WAIT_LOAD;
`endif
        end
`ifdef TL_RAM_WAIT_EN
        WAIT: begin
          if (wait_cnt_r == '0) begin
            state_r   <= RESP;
            d_valid_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r - CW'(1);
          end
        end
`endif
        RESP: begin
          if (d_fire_s) begin
            d_valid_r <= 1'b0;
            if (more_s) begin
              beats_left_r <= beats_left_r - 4'd1;
              idx_r        <= idx_r + AW'(1);
              state_r      <= READ;
            end else begin
              state_r   <= IDLE;
              a_ready_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          a_ready_r <= 1'b0;
          d_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_ready  = a_ready_r;
  assign bus.d_valid  = d_valid_r;
  assign bus.d_opcode = d_opcode_r;
  assign bus.d_size   = d_size_r;
  assign bus.d_source = d_source_r;
  assign bus.d_denied = d_denied_r;
  assign bus.d_data   = d_data_r;

endmodule

// File: tb/tb_tl_ram_slave.sv
// Directed bench for tl_ram_slave: Put/Get, partial writes, bursts, denials,
// backpressure and reset mid-burst. Latencies are counted in clock edges.
module tb_tl_ram_slave;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 1024;
`ifdef TL_RAM_WAIT_EN
  localparam int EW = 2;
`else
  localparam int EW = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  tl_ram_slave_if bus ();

  tl_ram_slave #(
    .BASE(BASE), .DEPTH(DEPTH), .MAX_SIZE(6), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                        input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
    int n = 0;
    bus.a_valid = 1'b1;  bus.a_opcode = op;  bus.a_size = size;  bus.a_source = src;
    bus.a_address = addr;  bus.a_mask = mask;  bus.a_data = data;
    while (!bus.a_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("a_accept", {63'd0, bus.a_ready}, 64'd1);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
  endtask

  task automatic recv_beat(input string tag, input logic [2:0] op, input logic [2:0] size,
                           input logic [3:0] src, input logic den, input bit chk_data,
                           input logic [63:0] data, input int lat, input int hold);
    int k = 0;
    while (!bus.d_valid && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check({tag, ".lat"},    64'(k + 1), 64'(lat));
    check({tag, ".op"},     {61'd0, bus.d_opcode}, {61'd0, op});
    check({tag, ".size"},   {61'd0, bus.d_size},   {61'd0, size});
    check({tag, ".src"},    {60'd0, bus.d_source}, {60'd0, src});
    check({tag, ".denied"}, {63'd0, bus.d_denied}, {63'd0, den});
    check({tag, ".a_rdy"},  {63'd0, bus.a_ready},  64'd0);
    if (chk_data) check({tag, ".data"}, bus.d_data, data);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_v"}, {63'd0, bus.d_valid}, 64'd1);
      if (chk_data) check({tag, ".hold_d"}, bus.d_data, data);
    end
    bus.d_ready = 1'b1;
    @(posedge clk); #1;
    bus.d_ready = 1'b0;
  endtask

  task automatic put(input string tag, input logic [2:0] op, input logic [63:0] addr,
                     input logic [63:0] data, input logic [7:0] mask);
    send_a(op, 3'd3, 4'd3, addr, mask, data);
    recv_beat(tag, 3'd0, 3'd3, 4'd3, 1'b0, 1'b0, 64'd0, 1 + EW, 0);
  endtask

  task automatic get1(input string tag, input logic [63:0] addr, input logic [63:0] exp);
    send_a(3'd4, 3'd3, 4'd5, addr, 8'hFF, 64'd0);
    recv_beat(tag, 3'd1, 3'd3, 4'd5, 1'b0, 1'b1, exp, 2 + EW, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.a_valid = 1'b0;  bus.a_opcode = 3'd0;  bus.a_size = 3'd0;  bus.a_source = 4'd0;
    bus.a_address = 64'd0;  bus.a_mask = 8'd0;  bus.a_data = 64'd0;  bus.d_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.a_ready",  {63'd0, bus.a_ready},  64'd0);
    check("rst.d_valid",  {63'd0, bus.d_valid},  64'd0);
    check("rst.d_opcode", {61'd0, bus.d_opcode}, 64'd0);
    check("rst.d_size",   {61'd0, bus.d_size},   64'd0);
    check("rst.d_source", {60'd0, bus.d_source}, 64'd0);
    check("rst.d_denied", {63'd0, bus.d_denied}, 64'd0);
    check("rst.d_data",   bus.d_data,            64'd0);
    rst_n = 1'b1;
    check("rst.a_ready_hold", {63'd0, bus.a_ready}, 64'd0);
    @(posedge clk); #1;
    check("rst.a_ready_rise", {63'd0, bus.a_ready}, 64'd1);

    put("putf", 3'd0, BASE + 64'h10, 64'h1122334455667788, 8'hFF);
    get1("get_full", BASE + 64'h10, 64'h1122334455667788);
    put("putp", 3'd1, BASE + 64'h10, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
    get1("get_part", BASE + 64'h10, 64'h11223344_BBBBBBBB);

    for (int i = 0; i < 8; i++) put($sformatf("pre%0d", i), 3'd0, BASE + 64'(8 * i), 64'(i + 1), 8'hFF);

    // Zero-mask PutFull is acked but leaves the word alone.
    put("put_mask0", 3'd0, BASE + 64'h18, 64'hDEAD_BEEF_0000_0000, 8'h00);
    get1("get_mask0", BASE + 64'h18, 64'd4);

    send_a(3'd4, 3'd6, 4'd1, BASE, 8'hFF, 64'd0);
    for (int i = 0; i < 8; i++)
      recv_beat($sformatf("burst%0d", i), 3'd1, 3'd6, 4'd1, 1'b0, 1'b1, 64'(i + 1), 2 + EW, 0);
    check("burst.a_ready_after", {63'd0, bus.a_ready}, 64'd1);

    send_a(3'd4, 3'd3, 4'd7, BASE + 64'(DEPTH * 8), 8'hFF, 64'd0);
    recv_beat("den_range", 3'd1, 3'd3, 4'd7, 1'b1, 1'b1, 64'd0, 1 + EW, 0);
    send_a(3'd4, 3'd3, 4'd7, BASE + 64'h4, 8'hFF, 64'd0);
    recv_beat("den_align", 3'd1, 3'd3, 4'd7, 1'b1, 1'b1, 64'd0, 1 + EW, 0);
    send_a(3'd0, 3'd4, 4'd2, BASE + 64'h20, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    recv_beat("den_putsz", 3'd0, 3'd4, 4'd2, 1'b1, 1'b0, 64'd0, 1 + EW, 0);
    send_a(3'd2, 3'd3, 4'd2, BASE + 64'h20, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    recv_beat("den_opc", 3'd0, 3'd3, 4'd2, 1'b1, 1'b0, 64'd0, 1 + EW, 0);
    get1("get_unchanged", BASE + 64'h20, 64'd5);

    send_a(3'd4, 3'd6, 4'd9, BASE, 8'hFF, 64'd0);
    for (int i = 0; i < 4; i++)
      recv_beat($sformatf("stall%0d", i), 3'd1, 3'd6, 4'd9, 1'b0, 1'b1, 64'(i + 1), 2 + EW, (i == 2) ? 5 : 0);
    begin
      int k = 0;
      while (!bus.d_valid && k < 50) begin
        @(posedge clk); #1; k++;
      end
      check("beat5.lat",  64'(k + 1), 64'(2 + EW));
      check("beat5.data", bus.d_data, 64'd5);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst.d_valid", {63'd0, bus.d_valid}, 64'd0);
    check("midrst.a_ready", {63'd0, bus.a_ready}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst.a_ready_rise", {63'd0, bus.a_ready}, 64'd1);
    get1("after_rst", BASE + 64'h10, 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
